// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered-read or first-word-fall-through output,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic rdAcc;
    logic wrAcc;

    // A pop frees a slot in the same edge, so a full FIFO can still take a write alongside it.
    assign rdAcc = rd_en & ~empty;
    assign wrAcc = wr_en & (~full | rdAcc);

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (rdAcc) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            count_d = count_q + CW'(wrAcc) - CW'(rdAcc);
            if (wr_en && !wrAcc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rdAcc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!flush && wrAcc) begin
            mem[wrPtr_q] <= data_in;
        end
    end

    generate
        if (FWFT) begin : gFwft
            assign data_out = empty ? '0 : mem[rdPtr_q];
            assign rd_valid = ~empty;
        end else begin : gRegRead
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  rdValid_q, rdValid_d;

            always_comb begin
                dout_d    = dout_q;
                rdValid_d = 1'b0;
                if (!flush && rdAcc) begin
                    dout_d    = mem[rdPtr_q];
                    rdValid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q    <= '0;
                    rdValid_q <= 1'b0;
                end else begin
                    dout_q    <= dout_d;
                    rdValid_q <= rdValid_d;
                end
            end

            assign data_out = dout_q;
            assign rd_valid = rdValid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Drives four FIFO builds (8x8 and 16x16, each in both read modes) with one stimulus stream
// and compares every output against a queue model on each falling clock edge.
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrEn, rdEn, flush, clrErr;
    logic [15:0] dataIn;

    logic [7:0]  doutA, doutB;
    logic [15:0] doutC, doutD;
    logic        rvA, fullA, emptyA, afA, aeA, ovA, unA;
    logic        rvB, fullB, emptyB, afB, aeB, ovB, unB;
    logic        rvC, fullC, emptyC, afC, aeC, ovC, unC;
    logic        rvD, fullD, emptyD, afD, aeD, ovD, unD;
    logic [3:0]  cntA, cntB;
    logic [4:0]  cntC, cntD;

    int nChecks = 0;
    int nPass   = 0;
    bit chkEn   = 1'b0;

    logic [15:0] mq [2][$];
    logic [15:0] mDout [2];
    bit          mRv [2];
    bit          mOv [2];
    bit          mUn [2];
    int          mDepth [2] = '{8, 16};
    logic [15:0] mMask [2]  = '{16'h00FF, 16'hFFFF};

    always #5 clk = ~clk;

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b0)) uA (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .data_in(dataIn[7:0]), .rd_en(rdEn),
        .flush(flush), .clr_err(clrErr), .data_out(doutA), .rd_valid(rvA), .full(fullA),
        .empty(emptyA), .almost_full(afA), .almost_empty(aeA), .count(cntA),
        .overflow(ovA), .underflow(unA));

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b1)) uB (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .data_in(dataIn[7:0]), .rd_en(rdEn),
        .flush(flush), .clr_err(clrErr), .data_out(doutB), .rd_valid(rvB), .full(fullB),
        .empty(emptyB), .almost_full(afB), .almost_empty(aeB), .count(cntB),
        .overflow(ovB), .underflow(unB));

    param_fifo #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b0)) uC (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .data_in(dataIn), .rd_en(rdEn),
        .flush(flush), .clr_err(clrErr), .data_out(doutC), .rd_valid(rvC), .full(fullC),
        .empty(emptyC), .almost_full(afC), .almost_empty(aeC), .count(cntC),
        .overflow(ovC), .underflow(unC));

    param_fifo #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b1)) uD (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .data_in(dataIn), .rd_en(rdEn),
        .flush(flush), .clr_err(clrErr), .data_out(doutD), .rd_valid(rvD), .full(fullD),
        .empty(emptyD), .almost_full(afD), .almost_empty(aeD), .count(cntD),
        .overflow(ovD), .underflow(unD));

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mDout[m] = '0;
            mRv[m]   = 1'b0;
            mOv[m]   = 1'b0;
            mUn[m]   = 1'b0;
        end
    endtask

    // Advances the model by one clock edge using the inputs held across that edge.
    task automatic modelStep();
        bit ra, wa;
        for (int m = 0; m < 2; m++) begin
            if (flush) begin
                mq[m].delete();
                mRv[m] = 1'b0;
                if (clrErr) begin
                    mOv[m] = 1'b0;
                    mUn[m] = 1'b0;
                end
            end else begin
                ra = rdEn && (mq[m].size() > 0);
                wa = wrEn && ((mq[m].size() < mDepth[m]) || ra);
                if (clrErr) begin
                    mOv[m] = 1'b0;
                    mUn[m] = 1'b0;
                end
                if (wrEn && !wa) mOv[m] = 1'b1;
                if (rdEn && !ra) mUn[m] = 1'b1;
                mRv[m] = ra;
                if (ra) mDout[m] = mq[m].pop_front();
                if (wa) mq[m].push_back(dataIn & mMask[m]);
            end
        end
    endtask

    task automatic checkOutput(input string nm, input int m, input bit fw,
                               input logic [15:0] dout, input logic rv, input logic fl,
                               input logic em, input logic af, input logic ae,
                               input logic [4:0] cnt, input logic ov, input logic un);
        int sz;
        sz = mq[m].size();
        cmp({nm, ".count"}, 16'(cnt), 16'(sz));
        cmp({nm, ".full"}, 16'(fl), 16'(sz == mDepth[m]));
        cmp({nm, ".empty"}, 16'(em), 16'(sz == 0));
        cmp({nm, ".almost_full"}, 16'(af), 16'(sz >= mDepth[m] - 1));
        cmp({nm, ".almost_empty"}, 16'(ae), 16'(sz <= 1));
        cmp({nm, ".overflow"}, 16'(ov), 16'(mOv[m]));
        cmp({nm, ".underflow"}, 16'(un), 16'(mUn[m]));
        if (fw) begin
            cmp({nm, ".rd_valid"}, 16'(rv), 16'(sz > 0));
            if (sz > 0) cmp({nm, ".data_out"}, dout, mq[m][0]);
        end else begin
            cmp({nm, ".rd_valid"}, 16'(rv), 16'(mRv[m]));
            cmp({nm, ".data_out"}, dout, mDout[m]);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("A", 0, 1'b0, {8'h00, doutA}, rvA, fullA, emptyA, afA, aeA, {1'b0, cntA}, ovA, unA);
            checkOutput("B", 0, 1'b1, {8'h00, doutB}, rvB, fullB, emptyB, afB, aeB, {1'b0, cntB}, ovB, unB);
            checkOutput("C", 1, 1'b0, doutC, rvC, fullC, emptyC, afC, aeC, cntC, ovC, unC);
            checkOutput("D", 1, 1'b1, doutD, rvD, fullD, emptyD, afD, aeD, cntD, ovD, unD);
        end
    end

    // Holds the given inputs across one rising edge, then returns 1 time unit after it.
    task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r,
                                 input logic f, input logic c);
        wrEn   = w;
        dataIn = d;
        rdEn   = r;
        flush  = f;
        clrErr = c;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        flush  = 1'b0;
        clrErr = 1'b0;
        dataIn = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.count", 16'(cntA), 16'd0);
        cmp("reset.empty", 16'(emptyA), 16'd1);
        cmp("reset.full", 16'(fullA), 16'd0);
        cmp("reset.almost_empty", 16'(aeA), 16'd1);
        cmp("reset.almost_full", 16'(afA), 16'd0);
        cmp("reset.data_out", 16'(doutA), 16'd0);
        cmp("reset.rd_valid", 16'(rvA), 16'd0);
        rst_n = 1'b1;
        chkEn = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        cmp("fill7.almost_full", 16'(afA), 16'd1);
        cmp("fill7.full", 16'(fullA), 16'd0);
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
        cmp("fill8.count", 16'(cntA), 16'd8);
        cmp("fill8.full", 16'(fullA), 16'd1);

        applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        cmp("ovf.count", 16'(cntA), 16'd8);
        cmp("ovf.overflow", 16'(ovA), 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cmp("clrerr.overflow", 16'(ovA), 16'd0);

        applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
        cmp("fullrw.count", 16'(cntA), 16'd8);
        cmp("fullrw.data_out", 16'(doutA), 16'h0000);
        cmp("fullrw.rd_valid", 16'(rvA), 16'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cmp("drain.last_data", 16'(doutA), 16'h00AA);
        cmp("drain.empty", 16'(emptyA), 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cmp("idle.rd_valid", 16'(rvA), 16'd0);

        applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
        cmp("emptyrw.count", 16'(cntA), 16'd1);
        cmp("emptyrw.underflow", 16'(unA), 16'd1);
        cmp("emptyrw.fwft_data", 16'(doutB), 16'h0055);
        cmp("emptyrw.fwft_valid", 16'(rvB), 16'd1);

        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        cmp("pre_flush.count", 16'(cntA), 16'd5);
        applyStimulus(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
        cmp("flush.count", 16'(cntA), 16'd0);
        cmp("flush.empty", 16'(emptyA), 16'd1);
        cmp("flush.overflow", 16'(ovA), 16'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cmp("pre_rst.data_out", 16'(doutA), 16'h0010);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        rdEn  = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        cmp("async_rst.count", 16'(cntA), 16'd0);
        cmp("async_rst.empty", 16'(emptyA), 16'd1);
        cmp("async_rst.data_out", 16'(doutA), 16'd0);
        cmp("async_rst.rd_valid", 16'(rvA), 16'd0);
        cmp("async_rst.fwft_valid", 16'(rvD), 16'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h003C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cmp("post_rst.data_out", 16'(doutA), 16'h003C);

        for (int i = 0; i < 2000; i++) begin
            logic w, r, f, c;
            w = $urandom_range(0, 99) < ((i < 1000) ? 70 : 35);
            r = $urandom_range(0, 99) < ((i < 1000) ? 40 : 65);
            f = ($urandom_range(0, 149) == 0);
            c = !f && ($urandom_range(0, 39) == 0);
            applyStimulus(w, 16'($urandom), r, f, c);
        end

        chkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, entries; power of two, >=2.
REQ-003 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL_TH, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-005 Parameter AEMPTY_TH, default 1, almost-empty threshold (0..DEPTH-1).
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write request.
REQ-009 data_in  in  DATA_WIDTH  write data.
REQ-010 rd_en  in  1  read request (pop).
REQ-011 flush  in  1  synchronous clear of contents.
REQ-012 clr_err  in  1  synchronous clear of sticky error flags.
REQ-013 data_out  out  DATA_WIDTH  read data.
REQ-014 rd_valid  out  1  data_out holds newly popped word (FWFT=0); equals !empty (FWFT=1).
REQ-015 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Storage: DEPTH x DATA_WIDTH array; rd_ptr/wr_ptr of $clog2(DEPTH) bits wrap DEPTH-1 -> 0 naturally.
REQ-019 wr_acc = wr_en & (!full | rd_acc); rd_acc = rd_en & !empty; evaluated on pre-edge state.
REQ-020 Simultaneous rd/wr when full: both accepted, count stays DEPTH, full stays 1.
REQ-021 Simultaneous rd/wr when empty: write accepted, read rejected (underflow set), count -> 1.
REQ-022 count next = count + wr_acc - rd_acc; never exceeds DEPTH nor goes below 0.
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH); all decoded from registered count, no extra latency.
REQ-024 FWFT=0: on rd_acc, data_out registers mem[rd_ptr] at that edge (1-cycle latency); rd_valid high exactly the following cycle; data_out otherwise holds last value.
REQ-025 FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty; rd_acc advances to next word; a word written into an empty FIFO is visible the cycle after the write edge.
REQ-026 Rejected write: memory, wr_ptr, count unchanged; overflow set to 1 at that edge.
REQ-027 Rejected read: rd_ptr, count, data_out unchanged; rd_valid low (FWFT=0); underflow set to 1.
REQ-028 overflow/underflow stay 1 until clr_err; if clr_err and a new error coincide, flag ends 1 (set wins).
REQ-029 flush: rd_ptr, wr_ptr, count -> 0 at edge; wr_en/rd_en ignored that cycle, no errors raised; rd_valid -> 0; sticky flags and data_out unchanged; memory contents need not be cleared.

Reset
REQ-030 rst_n low asynchronously forces: rd_ptr=wr_ptr=0, count=0, data_out=0, rd_valid=0, overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? n/a : 0).
REQ-031 Reset mid-operation discards all contents; first accepted write after deassertion goes to address 0.
REQ-032 Memory array needs no reset.

Verification
REQ-033 Defaults, FWFT=0: write 0..7 -> full=1, count=8, almost_full from count 7; read 8x -> data_out 0..7 in order, each with rd_valid one cycle after rd_en, then empty=1.
REQ-034 Full FIFO, wr_en with data 8'hFF -> count stays 8, overflow=1, later reads never return FF; clr_err -> overflow=0.
REQ-035 Full FIFO, wr_en+rd_en one cycle with 8'hAA -> count=8, pop returns oldest, AA returned eighth.
REQ-036 Empty, wr_en+rd_en with 8'h55 -> count=1, underflow=1; FWFT=1 build shows data_out=55, rd_valid=1 next cycle with no rd_en.
REQ-037 Count 5, flush with wr_en=1 -> count=0, empty=1, no overflow; rst_n pulsed low mid-stream -> all outputs at reset values immediately, before next clk edge.
REQ-038 Random 2000 cycles, DATA_WIDTH=16, DEPTH=16, both FWFT values, against a queue model: data order, count, all flags match every cycle.
